// File: rtl/jt89_mix_pkg.sv
// Shared definitions for the jt89 mixer: FSM encoding, gain constants and
// channel indices used by the mixer top and its bench.
package jt89_mix_pkg;

  // Mix sequencer states: one multiply-accumulate per channel, then saturate.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MAC0 = 3'd1,
    ST_MAC1 = 3'd2,
    ST_MAC2 = 3'd3,
    ST_MAC3 = 3'd4,
    ST_SAT  = 3'd5
  } state_t;

  // Default gain width and its unity value (Q2.6 -> 1.0 = 0x40).
  localparam int             GAIN_W_DEF = 8;
  localparam logic [GAIN_W_DEF-1:0] UNITY_GAIN = 8'h40;

  // Channel indices, shared by the gain write port and the MAC mux.
  localparam logic [1:0] CH_TONE0 = 2'd0;
  localparam logic [1:0] CH_TONE1 = 2'd1;
  localparam logic [1:0] CH_TONE2 = 2'd2;
  localparam logic [1:0] CH_NOISE = 2'd3;

endpackage

// File: rtl/jt89_sat.sv
// Arithmetic right shift (floor) followed by a signed clamp to OUT_W bits.
// Purely combinational.
module jt89_sat #(
  parameter int IN_W  = 21,
  parameter int SHIFT = 6,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);

  // Work width large enough to hold the shifted value and both clamp limits
  // regardless of whether OUT_W is wider or narrower than the shifted value.
  localparam int EW = IN_W + OUT_W;

  logic signed [IN_W-1:0] din_s;
  logic signed [IN_W-1:0] shr;
  logic signed [EW-1:0]   shr_ext;
  logic signed [EW-1:0]   max_v;
  logic signed [EW-1:0]   min_v;

  assign din_s   = din;
  assign shr     = din_s >>> SHIFT;
  assign shr_ext = {{OUT_W{shr[IN_W-1]}}, shr};
  assign max_v   = {{(IN_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  assign min_v   = {{(IN_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Clamp the floored value into the signed output range.
  always_comb begin
    dout = shr_ext[OUT_W-1:0];
    if (shr_ext > max_v) begin
      dout = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (shr_ext < min_v) begin
      dout = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

endmodule

// File: rtl/jt89_mixer.sv
// jt89 mixer: captures the four PSG channel outputs on a sample strobe, runs a
// single time-shared multiplier over them with per-channel gains, then shifts
// and saturates the sum into one mono sample.
//
// Handshake: clken is a one-cycle request accepted only in IDLE; a request
// while busy is dropped and flagged in the sticky ovr bit. snd_valid is a
// one-cycle pulse with no back-pressure; snd holds its value until the next.
module jt89_mixer
  import jt89_mix_pkg::*;
#(
  parameter int OUTW  = 16,
  parameter int GAINW = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clken,
  input  logic signed [9:0]       ch0,
  input  logic signed [9:0]       ch1,
  input  logic signed [9:0]       ch2,
  input  logic signed [9:0]       noise,
  input  logic                    gain_we,
  input  logic [1:0]              gain_sel,
  input  logic [GAINW-1:0]        gain_din,
  output logic signed [OUTW-1:0]  snd,
  output logic                    snd_valid,
  output logic                    busy,
  output logic                    ovr
);

  // Product of a signed 10-bit sample and a zero-extended gain; two guard bits
  // cover the sum of four products.
  localparam int PW   = 10 + GAINW + 1;
  localparam int ACCW = PW + 2;
  localparam logic [GAINW-1:0] UNITY = GAINW'(1) << (GAINW - 2);

  state_t state, state_nxt;

  logic signed [9:0]      cap      [4];
  logic [GAINW-1:0]       gain_pnd [4];
  logic [GAINW-1:0]       gain_act [4];
  logic                   start;
  logic                   mac_en;
  logic [1:0]             mac_idx;
  logic signed [9:0]      mul_a;
  logic signed [GAINW:0]  mul_b;
  logic signed [PW-1:0]   prod;
  logic signed [ACCW-1:0] acc;
  logic [OUTW-1:0]        sat_out;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: fixed walk through the four MAC slots and the saturate step.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (clken) state_nxt = ST_MAC0;
      ST_MAC0: state_nxt = ST_MAC1;
      ST_MAC1: state_nxt = ST_MAC2;
      ST_MAC2: state_nxt = ST_MAC3;
      ST_MAC3: state_nxt = ST_SAT;
      ST_SAT:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: busy flag, capture strobe and MAC channel select.
  always_comb begin
    busy    = (state != ST_IDLE);
    start   = (state == ST_IDLE) && clken;
    mac_en  = 1'b0;
    mac_idx = CH_TONE0;
    case (state)
      ST_MAC0: begin mac_en = 1'b1; mac_idx = CH_TONE0; end
      ST_MAC1: begin mac_en = 1'b1; mac_idx = CH_TONE1; end
      ST_MAC2: begin mac_en = 1'b1; mac_idx = CH_TONE2; end
      ST_MAC3: begin mac_en = 1'b1; mac_idx = CH_NOISE; end
      default: ;
    endcase
  end

  // Shared multiplier fed by the channel/gain mux.
  always_comb begin
    mul_a = cap[mac_idx];
    mul_b = $signed({1'b0, gain_act[mac_idx]});
    prod  = mul_a * mul_b;
  end

  // Pending gains: writable in any state; only reach the datapath at start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) gain_pnd[i] <= UNITY;
    end else if (gain_we) begin
      gain_pnd[gain_sel] <= gain_din;
    end
  end

  // Datapath: capture, accumulate, publish the saturated sample, flag overruns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        cap[i]      <= '0;
        gain_act[i] <= UNITY;
      end
      acc       <= '0;
      snd       <= '0;
      snd_valid <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      snd_valid <= 1'b0;
      if (start) begin
        cap[0] <= ch0;
        cap[1] <= ch1;
        cap[2] <= ch2;
        cap[3] <= noise;
        // A write landing in the same cycle as the strobe is used immediately.
        for (int i = 0; i < 4; i++) begin
          if (gain_we && gain_sel == 2'(i)) gain_act[i] <= gain_din;
          else                              gain_act[i] <= gain_pnd[i];
        end
        acc <= '0;
      end
      if (mac_en) acc <= acc + {{2{prod[PW-1]}}, prod};
      if (state == ST_SAT) begin
        snd       <= sat_out;
        snd_valid <= 1'b1;
      end
      if (clken && busy) ovr <= 1'b1;
    end
  end

  jt89_sat #(
    .IN_W  (ACCW),
    .SHIFT (GAINW - 2),
    .OUT_W (OUTW)
  ) u_sat (
    .din  (acc),
    .dout (sat_out)
  );

endmodule

// File: tb/tb_jt89_mixer.sv
// Directed bench for jt89_mixer. Two instances share all inputs: dut_a at the
// default 16-bit output, dut_b at a 10-bit output to exercise saturation.
module tb_jt89_mixer;
  import jt89_mix_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              clken = 1'b0;
  logic signed [9:0] ch0 = '0, ch1 = '0, ch2 = '0, noise = '0;
  logic              gain_we = 1'b0;
  logic [1:0]        gain_sel = '0;
  logic [7:0]        gain_din = '0;

  logic signed [15:0] snd_a;
  logic               snd_valid_a, busy_a, ovr_a;
  logic signed [9:0]  snd_b;
  logic               snd_valid_b, busy_b, ovr_b;

  int checks = 0;
  int errors = 0;

  // Results of the most recent run_mix call.
  int                 r_lat;
  int                 r_pulses;
  logic signed [15:0] r_va;
  logic signed [9:0]  r_vb;
  logic [5:0]         r_busy;

  jt89_mixer #(.OUTW(16), .GAINW(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .clken(clken),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .noise(noise),
    .gain_we(gain_we), .gain_sel(gain_sel), .gain_din(gain_din),
    .snd(snd_a), .snd_valid(snd_valid_a), .busy(busy_a), .ovr(ovr_a)
  );

  jt89_mixer #(.OUTW(10), .GAINW(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .clken(clken),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .noise(noise),
    .gain_we(gain_we), .gain_sel(gain_sel), .gain_din(gain_din),
    .snd(snd_b), .snd_valid(snd_valid_b), .busy(busy_b), .ovr(ovr_b)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clken = 1'b0;
    gain_we = 1'b0;
    ch0 = '0; ch1 = '0; ch2 = '0; noise = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Drivers
  task automatic set_ch(input int a, input int b, input int c, input int n);
    ch0 = 10'(a); ch1 = 10'(b); ch2 = 10'(c); noise = 10'(n);
  endtask

  task automatic write_gain(input logic [1:0] sel, input logic [7:0] val);
    gain_we = 1'b1; gain_sel = sel; gain_din = val;
    tick();
    gain_we = 1'b0;
  endtask

  // Strobe clken in cycle T, then watch 12 cycles recording the first pulse,
  // its cycle offset, the pulse count and busy over T+1..T+6.
  task automatic run_mix();
    r_lat = -1; r_pulses = 0; r_va = '0; r_vb = '0; r_busy = '0;
    clken = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) clken = 1'b0;
      if (c <= 6) r_busy[c-1] = busy_a;
      if (snd_valid_a) begin
        r_pulses++;
        if (r_lat < 0) begin
          r_lat = c; r_va = snd_a; r_vb = snd_b;
        end
      end
    end
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++; if (snd_a !== 16'sd0) begin errors++; $display("FAIL reset_snd: got %0d want 0", snd_a); end
    checks++; if (snd_valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", snd_valid_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    checks++; if (ovr_a !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", ovr_a); end
    apply_reset();
    checks++; if (busy_a !== 1'b0 || snd_b !== 10'sd0) begin errors++; $display("FAIL post_reset_idle: busy %b snd_b %0d want 0/0", busy_a, snd_b); end
  endtask

  task automatic test_basic();
    set_ch(100, 0, 0, 0);
    run_mix();
    checks++; if (r_lat !== 6) begin errors++; $display("FAIL basic_latency: got %0d want 6", r_lat); end
    checks++; if (r_va !== 16'sd100) begin errors++; $display("FAIL basic_snd: got %0d want 100", r_va); end
    checks++; if (r_pulses !== 1) begin errors++; $display("FAIL basic_pulses: got %0d want 1", r_pulses); end
    checks++; if (r_busy !== 6'b011111) begin errors++; $display("FAIL basic_busy: got %b want 011111", r_busy); end
    checks++; if (snd_a !== 16'sd100) begin errors++; $display("FAIL basic_hold: got %0d want 100", snd_a); end
  endtask

  task automatic test_full_scale();
    set_ch(-512, -512, -512, -512);
    run_mix();
    checks++; if (r_va !== -16'sd2048) begin errors++; $display("FAIL neg_full_16: got %0d want -2048", r_va); end
    checks++; if (r_vb !== -10'sd512) begin errors++; $display("FAIL neg_sat_10: got %0d want -512", r_vb); end
    set_ch(511, 511, 511, 511);
    run_mix();
    checks++; if (r_va !== 16'sd2044) begin errors++; $display("FAIL pos_full_16: got %0d want 2044", r_va); end
    checks++; if (r_vb !== 10'sd511) begin errors++; $display("FAIL pos_sat_10: got %0d want 511", r_vb); end
  endtask

  task automatic test_gains();
    write_gain(CH_TONE1, 8'h80);
    write_gain(CH_NOISE, 8'h00);
    set_ch(0, 300, 0, 200);
    run_mix();
    checks++; if (r_va !== 16'sd600) begin errors++; $display("FAIL gain_double_mute: got %0d want 600", r_va); end
    write_gain(CH_TONE0, 8'h20);
    set_ch(-3, 0, 0, 0);
    run_mix();
    checks++; if (r_va !== -16'sd2) begin errors++; $display("FAIL gain_floor: got %0d want -2", r_va); end
    // Same-cycle write and strobe: new ch0 gain 0x80 applies to this sample.
    set_ch(10, 0, 0, 0);
    gain_we = 1'b1; gain_sel = CH_TONE0; gain_din = 8'h80;
    run_mix();
    gain_we = 1'b0;
    checks++; if (r_va !== 16'sd20) begin errors++; $display("FAIL gain_bypass: got %0d want 20", r_va); end
  endtask

  task automatic test_overrun();
    int lat = -1, pulses = 0;
    logic signed [15:0] va = '0;
    apply_reset();
    set_ch(100, 0, 0, 0);
    clken = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      clken = (c == 2);
      if (c == 2) ch0 = 10'sd7;
      if (snd_valid_a) begin
        pulses++;
        if (lat < 0) begin lat = c; va = snd_a; end
      end
    end
    checks++; if (ovr_a !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b want 1", ovr_a); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL ovr_pulses: got %0d want 1", pulses); end
    checks++; if (lat !== 6 || va !== 16'sd100) begin errors++; $display("FAIL ovr_value: got %0d at %0d want 100 at 6", va, lat); end
  endtask

  task automatic test_midmix_gain_and_reset();
    int pulses = 0;
    logic signed [15:0] va = '0;
    apply_reset();
    set_ch(100, 5, 0, 0);
    clken = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) clken = 1'b0;
      if (c == 3) begin gain_we = 1'b1; gain_sel = CH_TONE0; gain_din = 8'h00; end
      if (c == 4) gain_we = 1'b0;
      if (snd_valid_a) begin pulses++; va = snd_a; end
    end
    checks++; if (pulses !== 1 || va !== 16'sd105) begin errors++; $display("FAIL midmix_gain_current: got %0d (%0d pulses) want 105", va, pulses); end
    run_mix();
    checks++; if (r_va !== 16'sd5) begin errors++; $display("FAIL midmix_gain_next: got %0d want 5", r_va); end
    // Reset in the middle of a mix: immediate abort, no pulse afterwards.
    pulses = 0;
    clken = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) clken = 1'b0;
      if (c == 3) begin
        rst_n = 1'b0;
        #1;
        checks++; if (busy_a !== 1'b0 || snd_a !== 16'sd0) begin errors++; $display("FAIL midmix_reset: busy %b snd %0d want 0/0", busy_a, snd_a); end
      end
      if (c == 5) rst_n = 1'b1;
      if (snd_valid_a) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midmix_reset_pulse: got %0d want 0", pulses); end
    checks++; if (ovr_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL midmix_reset_state: ovr %b busy %b want 0/0", ovr_a, busy_a); end
  endtask

  // Sequence and report
  initial begin
    test_reset();
    test_basic();
    test_full_scale();
    test_gains();
    test_overrun();
    test_midmix_gain_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
